fifo_wr_arbiter: RTL and testbench

//   Shares the single write port of one FIFO instance among N_REQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Bits needed to index 'value' items; never returns 0 so single-bit fields stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 3;
  localparam int BURST_DEF = 4;
  localparam int PTR_W     = clog2(N_REQ_DEF);
  localparam int DBG_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter: requests, data, grants and FIFO write pins.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  localparam int PW = clog2(N_REQ);

  // Handshake: req[i] is a valid beat on req_data[i*WIDTH +: WIDTH]; gnt[i] is the ready,
  // and the beat moves only in a cycle where req[i] && gnt[i]. req/data must stay stable until then.
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic [WIDTH-1:0]       fifo_data;
  logic [PW-1:0]          owner;
  logic                   busy;
  arb_state_t             dbg_state;
  logic [DBG_CNT_W-1:0]   dbg_beat_cnt;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr, fifo_data, owner, busy, dbg_state, dbg_beat_cnt
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr, fifo_data, owner, busy, dbg_state, dbg_beat_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set req bit after last_ptr, wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    last_ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  logic [N_REQ-1:0] hi_req;

  // Requests above last_ptr win first; otherwise wrap to the lowest set bit.
  // Masking by index (not by shifting) keeps non-power-of-two N_REQ correct.
  always_comb begin
    hi_req = '0;
    winner = '0;
    for (int j = 0; j < N_REQ; j++) begin
      hi_req[j] = req[j] && (PW'(j) > last_ptr);
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) winner = PW'(j);
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (hi_req[j]) winner = PW'(j);
    end
    valid = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, one beat per clock.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to BURST consecutive beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int BURST = BURST_DEF
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(BURST + 1);

  logic [PW-1:0] last_ptr;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] rr_winner;
  logic [PW-1:0] winner;
  logic          rr_valid;
  logic          hold;
  logic          xfer;
  arb_state_t    state, state_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .winner   (rr_winner),
    .valid    (rr_valid)
  );

  // Winner and transfer qualification; outputs are forced low while rst is asserted.
  always_comb begin
`ifdef FIFO_ARB_BURST_EN
    hold = (state == LOCK) && bus.req[owner_q];
`else
    hold = 1'b0;
`endif
    winner = hold ? owner_q : rr_winner;
    xfer   = rst && rr_valid && !bus.fifo_full;
  end

  always_comb begin
    bus.fifo_wr      = xfer;
    bus.gnt          = xfer ? (N_REQ'(1) << winner) : '0;
    bus.fifo_data    = xfer ? bus.req_data[int'(winner) * WIDTH +: WIDTH] : '0;
    bus.owner        = owner_q;
    bus.busy         = |bus.req;
    bus.dbg_state    = state;
    bus.dbg_beat_cnt = DBG_CNT_W'(beat_cnt);
  end

  // Next state: a stall (no transfer) holds everything unless the lock owner has withdrawn.
  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
`ifdef FIFO_ARB_BURST_EN
    case (state)
      ARB: begin
        if (xfer && (BURST > 1)) begin
          state_nx    = LOCK;
          beat_cnt_nx = CW'(1);
        end
      end
      LOCK: begin
        if (!bus.req[owner_q]) begin
          // Owner released: this cycle was a fresh round-robin pick from owner+1.
          if (xfer && (BURST > 1)) begin
            state_nx    = LOCK;
            beat_cnt_nx = CW'(1);
          end else begin
            state_nx    = ARB;
            beat_cnt_nx = '0;
          end
        end else if (xfer) begin
          if (int'(beat_cnt) + 1 >= BURST) begin
            state_nx    = ARB;
            beat_cnt_nx = '0;
          end else begin
            beat_cnt_nx = beat_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx    = ARB;
        beat_cnt_nx = '0;
      end
    endcase
`else
    state_nx    = ARB;
    beat_cnt_nx = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ptr <= PW'(N_REQ - 1);
      owner_q  <= '0;
      state    <= ARB;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      if (xfer) begin
        last_ptr <= winner;
        owner_q  <= winner;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a priority-list reference model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int B  = 4;
  localparam int DW = N * W;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fifo_q[$];

  // ---------------- reference model ----------------
  // Priority list: the requester after the last served one comes first; a burst owner
  // keeps the port while it still requests and has beats left.
  int m_last, m_owner, m_cnt;
  bit m_lock;

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = 0;
    m_cnt   = 0;
    m_lock  = 1'b0;
  endtask

  function automatic int model_winner(input logic [N-1:0] r);
    if (BURST_ON && m_lock && r[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] exp_gnt_f(input logic [N-1:0] r, input logic full);
    logic [N-1:0] g;
    g = '0;
    if ((|r) && !full) g[model_winner(r)] = 1'b1;
    return g;
  endfunction

  function automatic logic [W-1:0] exp_data_f(input logic [N-1:0] r, input logic full,
                                              input logic [DW-1:0] d);
    if (!((|r) && !full)) return '0;
    return d[model_winner(r) * W +: W];
  endfunction

  task automatic model_commit(input logic [N-1:0] r, input logic full);
    int w;
    if (!((|r) && !full)) begin
      if (BURST_ON && m_lock && !r[m_owner]) begin
        m_lock = 1'b0;
        m_cnt  = 0;
      end
      return;
    end
    w = model_winner(r);
    if (BURST_ON) begin
      if (m_lock && r[m_owner]) begin
        m_cnt++;
        if (m_cnt >= B) begin
          m_lock = 1'b0;
          m_cnt  = 0;
        end
      end else begin
        m_lock = (B > 1);
        m_cnt  = (B > 1) ? 1 : 0;
      end
    end
    m_last  = w;
    m_owner = w;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [N-1:0] r, input logic full, input bit new_data);
    bus.req       = r;
    bus.fifo_full = full;
    if (new_data) bus.req_data = DW'($urandom());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive('0, 1'b0, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(4'b1111, 1'b0, 1'b1);
    model_reset();
    #2;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.fifo_wr !== 1'b0 || bus.fifo_data !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b wr=%b data=%0d required 0000/0/0",
               bus.gnt, bus.fifo_wr, bus.fifo_data);
    end
    checks++;
    if (bus.owner !== 2'd0 || bus.dbg_state !== ARB || bus.dbg_beat_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state owner=%0d state=%0d cnt=%0d required 0/ARB/0",
               bus.owner, bus.dbg_state, bus.dbg_beat_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.gnt !== seq[i] || bus.fifo_wr !== 1'b1) begin
        failures++;
        $display("FAIL rr_gnt beat=%0d gnt=%b wr=%b required %b/1", i, bus.gnt, bus.fifo_wr, seq[i]);
      end
      checks++;
      if (bus.fifo_data !== bus.req_data[(i % N) * W +: W]) begin
        failures++;
        $display("FAIL rr_data beat=%0d data=%0d required %0d", i, bus.fifo_data,
                 bus.req_data[(i % N) * W +: W]);
      end
      model_commit(4'b1111, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_full_stall();
    logic [N-1:0] after [3] = '{4'b0101, 4'b0100, 4'b0000};
    do_reset();
    drive(4'b0101, 1'b1, 1'b1);
    exp_q.push_back(bus.req_data[0 * W +: W]);
    exp_q.push_back(bus.req_data[2 * W +: W]);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0101, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.gnt !== 4'b0000 || bus.fifo_wr !== 1'b0) begin
        failures++;
        $display("FAIL stall_full cyc=%0d gnt=%b wr=%b required 0000/0", i, bus.gnt, bus.fifo_wr);
      end
      model_commit(4'b0101, 1'b1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(after[i], 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.gnt !== exp_gnt_f(after[i], 1'b0)) begin
        failures++;
        $display("FAIL stall_release cyc=%0d gnt=%b required %b", i, bus.gnt,
                 exp_gnt_f(after[i], 1'b0));
      end
      if (bus.fifo_wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stall_extra_beat data=%0d required no write", bus.fifo_data);
        end else if (bus.fifo_data !== exp_q[0]) begin
          failures++;
          $display("FAIL stall_data data=%0d required %0d", bus.fifo_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      model_commit(after[i], 1'b0);
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_lost_beats left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_requester();
    logic [N-1:0] reqs [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
    logic [N-1:0] gnts [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(reqs[i], 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.gnt !== gnts[i] ||
          bus.fifo_data !== exp_data_f(reqs[i], 1'b0, bus.req_data)) begin
        failures++;
        $display("FAIL single_req cyc=%0d gnt=%b data=%0d required %b/%0d", i, bus.gnt,
                 bus.fifo_data, gnts[i], exp_data_f(reqs[i], 1'b0, bus.req_data));
      end
      model_commit(reqs[i], 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_burst();
`ifdef FIFO_ARB_BURST_EN
    logic [N-1:0] reqs [12] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                                4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011};
    logic [N-1:0] gnts [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
`else
    logic [N-1:0] reqs [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011};
    logic [N-1:0] gnts [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0001};
`endif
    do_reset();
    for (int i = 0; i < $size(reqs); i++) begin
      drive(reqs[i], 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.gnt !== gnts[i] || bus.gnt !== exp_gnt_f(reqs[i], 1'b0)) begin
        failures++;
        $display("FAIL burst_gnt cyc=%0d gnt=%b required %b", i, bus.gnt, gnts[i]);
      end
      model_commit(reqs[i], 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_fifo_stream();
    int writes;
    logic full;
    writes = 0;
    fifo_q.delete();
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      full = (fifo_q.size() == 4);
      drive(4'b1111, full, 1'b1);
      #1;
      checks++;
      if (bus.fifo_wr !== ((i < 4) || (i == 9))) begin
        failures++;
        $display("FAIL stream_wr cyc=%0d wr=%b required %b", i, bus.fifo_wr, (i < 4) || (i == 9));
      end
      if ((|bus.req) && !full) exp_q.push_back(exp_data_f(4'b1111, full, bus.req_data));
      if (bus.fifo_wr === 1'b1) begin
        writes++;
        fifo_q.push_back(bus.fifo_data);
        checks++;
        if (exp_q.size() == 0 || bus.fifo_data !== exp_q[0]) begin
          failures++;
          $display("FAIL stream_data cyc=%0d data=%0d required %0d", i, bus.fifo_data,
                   (exp_q.size() == 0) ? 0 : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      model_commit(4'b1111, full);
      if (i == 8) void'(fifo_q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (writes != 5 || fifo_q.size() != 4) begin
      failures++;
      $display("FAIL stream_count writes=%0d depth=%0d required 5/4", writes, fifo_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b0, 1'b1);
      model_commit(4'b1111, 1'b0);
      @(negedge clk);
    end
    drive(4'b1111, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.fifo_wr !== 1'b0 || bus.fifo_data !== 3'd0 ||
        bus.owner !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset gnt=%b wr=%b data=%0d owner=%0d required 0000/0/0/0",
               bus.gnt, bus.fifo_wr, bus.fifo_data, bus.owner);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset_first gnt=%b required 0001", bus.gnt);
    end
    model_commit(4'b1111, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic full;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r    = N'($urandom_range(0, 15));
      full = ($urandom_range(0, 3) == 0);
      drive(r, full, 1'b1);
      #1;
      checks++;
      if (bus.gnt !== exp_gnt_f(r, full) || bus.fifo_wr !== ((|r) && !full) ||
          bus.fifo_data !== exp_data_f(r, full, bus.req_data) ||
          bus.owner !== m_owner[1:0] || bus.busy !== (|r)) begin
        failures++;
        $display("FAIL random cyc=%0d req=%b full=%b gnt=%b wr=%b data=%0d owner=%0d busy=%b required gnt=%b data=%0d owner=%0d",
                 i, r, full, bus.gnt, bus.fifo_wr, bus.fifo_data, bus.owner, bus.busy,
                 exp_gnt_f(r, full), exp_data_f(r, full, bus.req_data), m_owner);
      end
      model_commit(r, full);
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_full_stall();
    test_single_requester();
    test_burst();
    test_fifo_stream();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
